// File: rtl/tap_delay_line.sv
// ============================================================================
//  Module      : tap_delay_line
//  Description : Qualified-shift sample delay line with fill tracking,
//                synchronous flush and an optional running sum of all taps
//                (enabled by defining TAP_DELAY_SUM_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tap_delay_line #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          sample_valid,
    input  logic                          flush,
    output logic [TAPS*WIDTH-1:0]         taps,
    output logic [$clog2(TAPS+1)-1:0]     fill_count,
    output logic                          primed,
    output logic                          shift_pulse
`ifdef TAP_DELAY_SUM_EN
    ,
    output logic [WIDTH+$clog2(TAPS)-1:0] sum_out
`endif
);

    localparam int                C_FILL_W = $clog2(TAPS + 1);
    localparam logic [C_FILL_W-1:0] C_FULL = C_FILL_W'(TAPS);

    logic [WIDTH-1:0]    taps_q [TAPS];
    logic [WIDTH-1:0]    taps_d [TAPS];
    logic [C_FILL_W-1:0] fill_q;
    logic [C_FILL_W-1:0] fill_d;
    logic                pulse_q;
    logic                pulse_d;

    // Flush outranks a sample; a simultaneous sample restarts the line with it.
    always_comb begin
        taps_d  = taps_q;
        fill_d  = fill_q;
        pulse_d = 1'b0;
        if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                taps_d[k] = '0;
            end
            fill_d = '0;
            if (sample_valid) begin
                taps_d[0] = sample_in;
                fill_d    = C_FILL_W'(1);
                pulse_d   = 1'b1;
            end
        end else if (sample_valid) begin
            for (int k = 1; k < TAPS; k++) begin
                taps_d[k] = taps_q[k-1];
            end
            taps_d[0] = sample_in;
            fill_d    = (fill_q == C_FULL) ? C_FULL : fill_q + C_FILL_W'(1);
            pulse_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= '0;
            end
            fill_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= taps_d[k];
            end
            fill_q  <= fill_d;
            pulse_q <= pulse_d;
        end
    end

    generate
        for (genvar g = 0; g < TAPS; g++) begin : g_flat
            assign taps[g*WIDTH +: WIDTH] = taps_q[g];
        end
    endgenerate

    assign fill_count  = fill_q;
    assign primed      = (fill_q == C_FULL);
    assign shift_pulse = pulse_q;

`ifdef TAP_DELAY_SUM_EN
    localparam int C_SUM_W = WIDTH + $clog2(TAPS);

    logic [C_SUM_W-1:0] sum_q;
    logic [C_SUM_W-1:0] sum_d;

    // Incremental update; the width bound keeps the intermediate result exact.
    always_comb begin
        sum_d = sum_q;
        if (flush) begin
            sum_d = sample_valid ? C_SUM_W'(sample_in) : '0;
        end else if (sample_valid) begin
            sum_d = sum_q + C_SUM_W'(sample_in) - C_SUM_W'(taps_q[TAPS-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tap_delay_line.sv
// ============================================================================
//  Module      : tb_tap_delay_line
//  Description : Scoreboard bench for tap_delay_line (sum checks active when
//                TAP_DELAY_SUM_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tap_delay_line;

    localparam int WIDTH = 8;
    localparam int TAPS  = 4;
    localparam int FW    = $clog2(TAPS + 1);
    localparam int SW    = WIDTH + $clog2(TAPS);

    logic                  clk;
    logic                  rst_n;
    logic [WIDTH-1:0]      sample_in;
    logic                  sample_valid;
    logic                  flush;
    logic [TAPS*WIDTH-1:0] taps;
    logic [FW-1:0]         fill_count;
    logic                  primed;
    logic                  shift_pulse;
    logic [SW-1:0]         sum_obs;

    tap_delay_line #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .taps         (taps),
        .fill_count   (fill_count),
        .primed       (primed),
`ifdef TAP_DELAY_SUM_EN
        .shift_pulse  (shift_pulse),
        .sum_out      (sum_obs)
`else
        .shift_pulse  (shift_pulse)
`endif
    );

`ifndef TAP_DELAY_SUM_EN
    assign sum_obs = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAPS*WIDTH-1:0] taps;
        logic [FW-1:0]         fill;
        logic                  primed;
        logic                  pulse;
        logic [SW-1:0]         sum;
    } exp_t;

    exp_t             sb[$];
    exp_t             e;
    logic [WIDTH-1:0] m_taps [TAPS];
    int               m_fill;
    logic [SW-1:0]    m_sum;
    int               n_cmp;
    int               n_bad;

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) m_taps[k] = '0;
        m_fill = 0;
        m_sum  = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, push the expected post-edge state, sample #1 after the edge.
    task automatic step(input logic v, input logic f, input logic [WIDTH-1:0] s);
        exp_t x;
        @(negedge clk);
        sample_valid = v;
        flush        = f;
        sample_in    = s;
        x.pulse      = v;
        if (f) begin
            for (int k = 0; k < TAPS; k++) m_taps[k] = '0;
            m_fill = 0;
            m_sum  = '0;
            if (v) begin
                m_taps[0] = s;
                m_fill    = 1;
                m_sum     = SW'(s);
            end
        end else if (v) begin
            m_sum = m_sum + SW'(s) - SW'(m_taps[TAPS-1]);
            for (int k = TAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
            m_taps[0] = s;
            if (m_fill < TAPS) m_fill++;
        end
        for (int k = 0; k < TAPS; k++) x.taps[k*WIDTH +: WIDTH] = m_taps[k];
        x.fill   = FW'(m_fill);
        x.primed = (m_fill == TAPS);
        x.sum    = m_sum;
        sb.push_back(x);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0; flush = 1'b0; sample_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({taps, fill_count, primed, shift_pulse, sum_obs} !== '0) begin
            n_bad++;
            $display("FAIL reset_init: got taps=%h fill=%0d primed=%b pulse=%b sum=%h, want all 0",
                     taps, fill_count, primed, shift_pulse, sum_obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
        n_cmp++;
        if (taps !== 32'h11223344) begin
            n_bad++;
            $display("FAIL reset_preload: got taps=%h want 11223344", taps);
        end
        sb.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({taps, fill_count, primed, shift_pulse, sum_obs} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got taps=%h fill=%0d primed=%b pulse=%b sum=%h, want all 0",
                     taps, fill_count, primed, shift_pulse, sum_obs);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        step(0, 1, 8'h00);
        void'(sb.pop_front());
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, WIDTH'(i));
            e = sb.pop_front();
            n_cmp++;
            if ({taps, fill_count, primed, shift_pulse} !== {e.taps, e.fill, e.primed, e.pulse}) begin
                n_bad++;
                $display("FAIL fill_%0d: got taps=%h fill=%0d primed=%b pulse=%b want taps=%h fill=%0d primed=%b pulse=%b",
                         i, taps, fill_count, primed, shift_pulse, e.taps, e.fill, e.primed, e.pulse);
            end
`ifdef TAP_DELAY_SUM_EN
            n_cmp++;
            if (sum_obs !== e.sum) begin
                n_bad++;
                $display("FAIL fill_sum_%0d: got %h want %h", i, sum_obs, e.sum);
            end
`endif
            if (i == 3) begin
                n_cmp++;
                if (primed !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fill_not_primed_3: got %b want 0", primed);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if ({taps, fill_count, primed} !== {32'h01020304, 3'd4, 1'b1}) begin
                    n_bad++;
                    $display("FAIL fill_4_const: got taps=%h fill=%0d primed=%b want 01020304 4 1",
                             taps, fill_count, primed);
                end
`ifdef TAP_DELAY_SUM_EN
                n_cmp++;
                if (sum_obs !== 10'h00A) begin
                    n_bad++;
                    $display("FAIL fill_sum_4_const: got %h want 00a", sum_obs);
                end
`endif
            end
            if (i == 5) begin
                n_cmp++;
                if ({taps, fill_count} !== {32'h02030405, 3'd4}) begin
                    n_bad++;
                    $display("FAIL fill_5_const: got taps=%h fill=%0d want 02030405 4", taps, fill_count);
                end
`ifdef TAP_DELAY_SUM_EN
                n_cmp++;
                if (sum_obs !== 10'h00E) begin
                    n_bad++;
                    $display("FAIL fill_sum_5_const: got %h want 00e", sum_obs);
                end
`endif
            end
        end
    endtask

    task automatic test_gaps();
        int pulses;
        logic [TAPS*WIDTH-1:0] prev;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            prev = taps;
            if (i == 0)      step(1, 0, 8'hAA);
            else if (i == 4) step(1, 0, 8'hBB);
            else             step(0, 0, 8'h5A);
            e = sb.pop_front();
            if (shift_pulse === 1'b1) pulses++;
            n_cmp++;
            if ({taps, fill_count, shift_pulse} !== {e.taps, e.fill, e.pulse}) begin
                n_bad++;
                $display("FAIL gaps_%0d: got taps=%h fill=%0d pulse=%b want taps=%h fill=%0d pulse=%b (prev %h)",
                         i, taps, fill_count, shift_pulse, e.taps, e.fill, e.pulse, prev);
            end
        end
        n_cmp++;
        if (pulses !== 2 || taps[15:0] !== 16'hAABB) begin
            n_bad++;
            $display("FAIL gaps_summary: got pulses=%0d tap1_tap0=%h want 2 aabb", pulses, taps[15:0]);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 8'h00);
        e = sb.pop_front();
        n_cmp++;
        if ({taps, fill_count, primed, shift_pulse, sum_obs} !== '0 || e.fill !== '0) begin
            n_bad++;
            $display("FAIL flush_clear: got taps=%h fill=%0d primed=%b pulse=%b sum=%h want all 0",
                     taps, fill_count, primed, shift_pulse, sum_obs);
        end
        step(1, 1, 8'h7F);
        e = sb.pop_front();
        n_cmp++;
        if ({taps, fill_count, primed, shift_pulse} !== {32'h0000007F, 3'd1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_restart: got taps=%h fill=%0d primed=%b pulse=%b want 0000007f 1 0 1",
                     taps, fill_count, primed, shift_pulse);
        end
`ifdef TAP_DELAY_SUM_EN
        n_cmp++;
        if (sum_obs !== 10'h07F) begin
            n_bad++;
            $display("FAIL flush_restart_sum: got %h want 07f", sum_obs);
        end
`endif
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 8'hFF);
            e = sb.pop_front();
        end
        n_cmp++;
        if ({taps, fill_count, primed} !== {32'hFFFFFFFF, 3'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL saturate: got taps=%h fill=%0d primed=%b want ffffffff 4 1", taps, fill_count, primed);
        end
`ifdef TAP_DELAY_SUM_EN
        n_cmp++;
        if (sum_obs !== 10'h3FC) begin
            n_bad++;
            $display("FAIL saturate_sum: got %h want 3fc", sum_obs);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), WIDTH'($urandom));
            e = sb.pop_front();
            n_cmp++;
            if ({taps, fill_count, primed, shift_pulse} !== {e.taps, e.fill, e.primed, e.pulse}) begin
                n_bad++;
                $display("FAIL b2b_%0d: got taps=%h fill=%0d primed=%b pulse=%b want taps=%h fill=%0d primed=%b pulse=%b",
                         i, taps, fill_count, primed, shift_pulse, e.taps, e.fill, e.primed, e.pulse);
            end
`ifdef TAP_DELAY_SUM_EN
            n_cmp++;
            if (sum_obs !== e.sum) begin
                n_bad++;
                $display("FAIL b2b_sum_%0d: got %h want %h", i, sum_obs, e.sum);
            end
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fill();
        test_gaps();
        test_fill();
        test_flush();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
